// File: rtl/demux_4to16_reg.sv
// demux_4to16_reg: steers a DATA_W-bit lane word into one of four registered
// group slots (a..d). Each slot has its own valid/ack handshake. The input side
// uses a valid/ready handshake.
// When the macro DEMUX_AUTO_SEQ_EN is defined, auto_mode selects a round-robin
// pointer instead of the selector. When it is undefined, auto_mode is ignored
// and ptr reads 0.
module demux_4to16_reg #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        selector,
  input  logic              auto_mode,
  output logic [DATA_W-1:0] grp_a,
  output logic [DATA_W-1:0] grp_b,
  output logic [DATA_W-1:0] grp_c,
  output logic [DATA_W-1:0] grp_d,
  output logic [3:0]        grp_valid,
  input  logic [3:0]        grp_ack,
  output logic [1:0]        ptr,
  output logic              frame_done
);

  logic [1:0]        r_rst_sync;
  logic              w_run;
  logic [1:0]        w_dst;
  logic              w_ready;
  logic              w_xfer;
  logic [3:0]        w_load;
  logic [3:0]        w_valid_nxt;
  logic [3:0]        r_valid;
  logic [DATA_W-1:0] r_grp [4];
  logic              r_frame_done;

  // Reset is asserted asynchronously and released through two flops. Transfers
  // are blocked until the second flop sets, so the first load can happen no
  // earlier than the third rising edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_run = r_rst_sync[1];

`ifdef DEMUX_AUTO_SEQ_EN
  logic [1:0] r_ptr;

  assign w_dst = auto_mode ? r_ptr : selector;
  assign ptr   = r_ptr;

  // The round-robin pointer steps only on a transfer made in auto mode. It
  // holds on a stall, and a change of mode does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_ptr <= '0;
    else if (w_xfer && auto_mode) r_ptr <= r_ptr + 2'd1;
  end
`else
  logic w_unused_auto;

  assign w_unused_auto = auto_mode;
  assign w_dst         = selector;
  assign ptr           = '0;
`endif

  // Readiness is masked during the reset-release window. This prevents the
  // source from seeing a handshake that the registers would then ignore.
  assign w_ready  = w_run & (~r_valid[w_dst] | grp_ack[w_dst]);
  assign w_xfer   = in_valid & w_ready;
  assign in_ready = w_ready;

  // One-hot load strobe and next valid vector. A load on a slot wins over a
  // same-cycle ack on that slot, which gives full throughput. An ack on an
  // empty slot has no effect.
  always_comb begin
    w_load = '0;
    if (w_xfer) w_load[w_dst] = 1'b1;
    w_valid_nxt = (r_valid & ~grp_ack) | w_load;
  end

  // Group data registers. Only the selected slot loads, so the other slots
  // keep their words. An acked slot keeps its last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned g = 0; g < 4; g++) r_grp[g] <= '0;
    end else begin
      for (int unsigned g = 0; g < 4; g++) begin
        if (w_load[g]) r_grp[g] <= in_data;
      end
    end
  end

  // Valid flags. frame_done is high during the first cycle in which every
  // slot is full after a cycle in which at least one slot was empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid      <= w_valid_nxt;
      r_frame_done <= (&w_valid_nxt) & ~(&r_valid);
    end
  end

  assign grp_a      = r_grp[0];
  assign grp_b      = r_grp[1];
  assign grp_c      = r_grp[2];
  assign grp_d      = r_grp[3];
  assign grp_valid  = r_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_demux_4to16_reg.sv
// Bench for demux_4to16_reg with directed vectors and hand-computed
// expectations. The auto-sequencer cases are built only when DEMUX_AUTO_SEQ_EN
// is defined. The other builds check that auto_mode is ignored.
module tb_demux_4to16_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = '0;
  logic [1:0]  selector = '0;
  logic        auto_mode = 1'b0;
  logic [3:0]  grp_a, grp_b, grp_c, grp_d;
  logic [3:0]  grp_valid;
  logic [3:0]  grp_ack = '0;
  logic [1:0]  ptr;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;

  demux_4to16_reg #(.DATA_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .selector  (selector),
    .auto_mode (auto_mode),
    .grp_a     (grp_a),
    .grp_b     (grp_b),
    .grp_c     (grp_c),
    .grp_d     (grp_d),
    .grp_valid (grp_valid),
    .grp_ack   (grp_ack),
    .ptr       (ptr),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Count frame_done pulses, sampled away from the active edge.
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  data;
    logic        vld;
    logic [3:0]  ack;
    logic        exp_rdy;
    logic [3:0]  exp_gv;
    logic [15:0] exp_grp;   // {d,c,b,a}
    logic        exp_fd;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] grps();
    return {grp_d, grp_c, grp_b, grp_a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, release it after an edge, then wait out the release
  // synchroniser. The task returns 1 ns after an edge with transfers enabled.
  task automatic do_reset();
    in_valid = 1'b0; grp_ack = '0; auto_mode = 1'b0; selector = '0; in_data = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int base;

    vecs[0]  = '{2'd2, 4'hA, 1'b1, 4'b0000, 1'b1, 4'b0100, 16'h0A00, 1'b0};
    vecs[1]  = '{2'd1, 4'h3, 1'b1, 4'b0000, 1'b1, 4'b0110, 16'h0A30, 1'b0};
    vecs[2]  = '{2'd1, 4'h7, 1'b1, 4'b0000, 1'b0, 4'b0110, 16'h0A30, 1'b0};
    vecs[3]  = '{2'd1, 4'h7, 1'b1, 4'b0000, 1'b0, 4'b0110, 16'h0A30, 1'b0};
    vecs[4]  = '{2'd1, 4'h7, 1'b1, 4'b0000, 1'b0, 4'b0110, 16'h0A30, 1'b0};
    vecs[5]  = '{2'd1, 4'h7, 1'b1, 4'b0010, 1'b1, 4'b0110, 16'h0A70, 1'b0};
    vecs[6]  = '{2'd0, 4'h5, 1'b0, 4'b0100, 1'b1, 4'b0010, 16'h0A70, 1'b0};
    vecs[7]  = '{2'd3, 4'h9, 1'b0, 4'b0001, 1'b1, 4'b0010, 16'h0A70, 1'b0};
    vecs[8]  = '{2'd0, 4'h1, 1'b1, 4'b0000, 1'b1, 4'b0011, 16'h0A71, 1'b0};
    vecs[9]  = '{2'd2, 4'hC, 1'b1, 4'b0000, 1'b1, 4'b0111, 16'h0C71, 1'b0};
    vecs[10] = '{2'd3, 4'hE, 1'b1, 4'b0000, 1'b1, 4'b1111, 16'hEC71, 1'b1};
    vecs[11] = '{2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 4'b1111, 16'hFC71, 1'b0};
    vecs[12] = '{2'd0, 4'h2, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'hFC71, 1'b0};
    vecs[13] = '{2'd0, 4'h4, 1'b1, 4'b0000, 1'b1, 4'b0001, 16'hFC74, 1'b0};

    // Values while reset is asserted.
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_grp", grps(), 16'h0000);
    chk("rst_valid", grp_valid, 4'b0000);
    chk("rst_ptr", ptr, 2'd0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_ready", in_ready, 1'b0);

    // A word offered right at release must not load on the first two edges.
    tick();
    in_valid = 1'b1; selector = 2'd0; in_data = 4'h5;
    rst_n = 1'b1;
    tick();
    chk("sync_edge1_valid", grp_valid, 4'b0000);
    tick();
    chk("sync_edge2_valid", grp_valid, 4'b0000);
    in_valid = 1'b0;
    do_reset();

    // Manual-mode table.
    for (int i = 0; i < 14; i++) begin
      selector = vecs[i].sel; in_data = vecs[i].data;
      in_valid = vecs[i].vld; grp_ack = vecs[i].ack;
      #3;
      chk($sformatf("v%0d_ready", i), in_ready, vecs[i].exp_rdy);
      tick();
      chk($sformatf("v%0d_valid", i), grp_valid, vecs[i].exp_gv);
      chk($sformatf("v%0d_grp", i), grps(), vecs[i].exp_grp);
      chk($sformatf("v%0d_fd", i), frame_done, vecs[i].exp_fd);
      chk($sformatf("v%0d_ptr", i), ptr, 2'd0);
    end
    in_valid = 1'b0; grp_ack = '0;

    // Reset in the middle of a stream while grp_valid is 1011.
    in_valid = 1'b1; selector = 2'd1; in_data = 4'h6;
    tick();
    selector = 2'd3; in_data = 4'h8;
    tick();
    chk("pre_rst_valid", grp_valid, 4'b1011);
    selector = 2'd2; in_data = 4'hD;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", grp_valid, 4'b0000);
    chk("mid_rst_grp", grps(), 16'h0000);
    chk("mid_rst_ready", in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_e1_valid", grp_valid, 4'b0000);
    tick();
    chk("post_rst_e2_grp", grps(), 16'h0000);
    tick();
    chk("post_rst_e3_valid", grp_valid, 4'b0100);
    chk("post_rst_e3_grp", grps(), 16'h0D00);
    in_valid = 1'b0;

`ifdef DEMUX_AUTO_SEQ_EN
    // Four back-to-back words fill a..d. The fifth word stalls until an ack.
    do_reset();
    auto_mode = 1'b1;
    base = fd_cnt;
    for (int w = 1; w <= 4; w++) begin
      in_data = 4'(w); in_valid = 1'b1;
      #3;
      chk($sformatf("auto_w%0d_ready", w), in_ready, 1'b1);
      tick();
    end
    chk("auto_grp", grps(), 16'h4321);
    chk("auto_valid", grp_valid, 4'b1111);
    chk("auto_ptr_wrap", ptr, 2'd0);
    in_data = 4'h5;
    #3;
    chk("auto_w5_stall", in_ready, 1'b0);
    tick();
    tick();
    chk("auto_stall_ptr", ptr, 2'd0);
    chk("auto_stall_grpa", grp_a, 4'h1);
    chk("auto_fd_once", fd_cnt - base, 1);
    grp_ack = 4'b0001;
    #3;
    chk("auto_w5_ready", in_ready, 1'b1);
    tick();
    chk("auto_w5_grpa", grp_a, 4'h5);
    chk("auto_w5_ptr", ptr, 2'd1);
    chk("auto_w5_valid", grp_valid, 4'b1111);
    grp_ack = '0; in_valid = 1'b0;
    tick();
    chk("auto_fd_still_once", fd_cnt - base, 1);

    // The pointer holds across idle cycles. It is kept when auto_mode changes.
    do_reset();
    auto_mode = 1'b1;
    in_valid = 1'b1; in_data = 4'h1; tick();
    in_data = 4'h2; tick();
    in_valid = 1'b0;
    tick();
    chk("gap_ptr1", ptr, 2'd2);
    tick();
    chk("gap_ptr2", ptr, 2'd2);
    in_valid = 1'b1; in_data = 4'h7; tick();
    chk("gap_grpc", grp_c, 4'h7);
    chk("gap_ptr3", ptr, 2'd3);
    chk("gap_valid", grp_valid, 4'b0111);
    in_valid = 1'b0; grp_ack = 4'b0101; tick();
    grp_ack = '0;
    auto_mode = 1'b0; selector = 2'd0; in_data = 4'h9; in_valid = 1'b1; tick();
    chk("man_grpa", grp_a, 4'h9);
    chk("man_ptr_kept", ptr, 2'd3);
    auto_mode = 1'b1; in_data = 4'h6; tick();
    chk("auto_again_grpd", grp_d, 4'h6);
    chk("auto_again_ptr", ptr, 2'd0);
    in_valid = 1'b0;
`else
    // auto_mode must have no effect: the selector picks group d.
    base = fd_cnt;
    auto_mode = 1'b1; selector = 2'd3; in_data = 4'hB; in_valid = 1'b1;
    #3;
    chk("noauto_ready", in_ready, 1'b1);
    tick();
    chk("noauto_grpd", grp_d, 4'hB);
    chk("noauto_valid", grp_valid, 4'b1100);
    chk("noauto_ptr", ptr, 2'd0);
    in_valid = 1'b0; auto_mode = 1'b0;
    tick();
    chk("noauto_fd_none", fd_cnt - base, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
